// File: rtl/pipe_stage_elastic.sv
// Elastic 2-entry (main + skid) pipeline register with valid/ready on both sides and synchronous flush.
// Optional perf counters (stall_cnt, bubble_cnt) are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_elastic #(
  parameter int                DATA_W   = 32,
  parameter int                N_FIELDS = 5,
  parameter logic [DATA_W-1:0] RESET_PC = 'h00003000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_ir,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic [N_FIELDS*DATA_W-1:0] in_payload,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_ir,
  output logic [DATA_W-1:0]          out_pc,
  output logic [N_FIELDS*DATA_W-1:0] out_payload,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                bubble_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0]          ir;
    logic [DATA_W-1:0]          pc;
    logic [N_FIELDS*DATA_W-1:0] payload;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam entry_t BUBBLE = '{ir: '0, pc: RESET_PC, payload: '0};

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry  = '{ir: in_ir, pc: in_pc, payload: in_payload};
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // The head entry is always main; it is held at BUBBLE whenever the stage is empty.
  assign out_ir      = main_q.ir;
  assign out_pc      = main_q.pc;
  assign out_payload = main_q.payload;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_ONE;
            main_d  = in_entry;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            state_d = S_FULL;
            skid_d  = in_entry;
          end else if (out_fire) begin
            state_d = S_EMPTY;
            main_d  = BUBBLE;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
    // Registered from the next state so in_ready has no combinational path from out_ready.
    in_ready_d = (state_d != S_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush deliberately leaves them untouched.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!out_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = 32'd0;
  assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed, table-driven bench for pipe_stage_elastic plus hand-written async-reset and perf-counter sequences.
module tb_pipe_stage_elastic;
  localparam int DATA_W   = 32;
  localparam int N_FIELDS = 5;
  localparam int PW       = N_FIELDS * DATA_W;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_ir;
  logic [31:0]   in_pc;
  logic [PW-1:0] in_payload;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_ir;
  logic [31:0]   out_pc;
  logic [PW-1:0] out_payload;
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DATA_W), .N_FIELDS(N_FIELDS), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_pc(out_pc), .out_payload(out_payload),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // Stimulus encoding: PC and payload are derived from IR; IR=0 means an empty (bubble) entry.
  function automatic logic [31:0] pc_of(input logic [31:0] ir);
    return (ir == 32'd0) ? RST_PC : (32'h0000_1000 + ir * 32'd4);
  endfunction

  function automatic logic [PW-1:0] pl_of(input logic [31:0] ir);
    logic [PW-1:0] p;
    p = '0;
    if (ir != 32'd0)
      for (int k = 0; k < N_FIELDS; k++) p[k*DATA_W +: DATA_W] = ir + 32'(k) * 32'h100;
    return p;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic ev, input logic erdy, input logic [31:0] eir);
    chk({tag, ".out_valid"}, PW'(out_valid), PW'(ev));
    chk({tag, ".in_ready"}, PW'(in_ready), PW'(erdy));
    chk({tag, ".out_ir"}, PW'(out_ir), PW'(eir));
    chk({tag, ".out_pc"}, PW'(out_pc), PW'(pc_of(eir)));
    chk({tag, ".out_payload"}, out_payload, pl_of(eir));
  endtask

  task automatic drive(input logic iv, input logic [31:0] ir, input logic ordy, input logic fl);
    in_valid   = iv;
    in_ir      = ir;
    in_pc      = pc_of(ir);
    in_payload = pl_of(ir);
    out_ready  = ordy;
    flush      = fl;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ir;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic        e_ird;
    logic [31:0] e_ir;
  } vec_t;

  vec_t vq[$];

  initial begin
    // Streaming IR=1..4 then drain
    vq.push_back('{1'b1, 32'h1,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1});
    vq.push_back('{1'b1, 32'h2,  1'b1, 1'b0, 1'b1, 1'b1, 32'h2});
    vq.push_back('{1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h3});
    vq.push_back('{1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4});
    vq.push_back('{1'b0, 32'h5,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
    // Backpressure: A then B, C refused while FULL, then drain A, B
    vq.push_back('{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA});
    vq.push_back('{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA});
    vq.push_back('{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA});
    vq.push_back('{1'b0, 32'hC,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB});
    vq.push_back('{1'b0, 32'hC,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
    // Flush while FULL with in_valid=1 and out_ready=1
    vq.push_back('{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11});
    vq.push_back('{1'b1, 32'h12, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11});
    vq.push_back('{1'b1, 32'h13, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0});
    vq.push_back('{1'b0, 32'h13, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
    // Flush while ONE discards a same-cycle in_fire
    vq.push_back('{1'b1, 32'h21, 1'b0, 1'b0, 1'b1, 1'b1, 32'h21});
    vq.push_back('{1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0});
    vq.push_back('{1'b0, 32'h22, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
    // FULL -> ONE with skid promoted, then simultaneous in/out while ONE
    vq.push_back('{1'b1, 32'h31, 1'b0, 1'b0, 1'b1, 1'b1, 32'h31});
    vq.push_back('{1'b1, 32'h32, 1'b0, 1'b0, 1'b1, 1'b0, 32'h31});
    vq.push_back('{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1, 32'h32});
    vq.push_back('{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33});
    vq.push_back('{1'b0, 32'h34, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0});

    drive(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    #12;
    chk_head("reset_held", 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_head("reset", 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].iv, vq[i].ir, vq[i].ordy, vq[i].fl);
      @(posedge clk);
      #1;
      chk_head($sformatf("vec%0d", i), vq[i].e_ov, vq[i].e_ird, vq[i].e_ir);
    end

    // Async reset mid-cycle while ONE
    @(negedge clk);
    drive(1'b1, 32'h51, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_head("pre_async", 1'b1, 1'b1, 32'h51);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_head("async_reset", 1'b0, 1'b1, 32'h0);
    chk("async_reset.stall_cnt", PW'(stall_cnt), PW'(0));
    chk("async_reset.bubble_cnt", PW'(bubble_cnt), PW'(0));

    // Perf: 2 empty cycles then 3 stalled cycles
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h61, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_head("perf_head", 1'b1, 1'b1, 32'h61);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf.stall_cnt", PW'(stall_cnt), PW'(3));
    chk("perf.bubble_cnt", PW'(bubble_cnt), PW'(2));
    // Flush must not clear the counters; the flush cycle itself is a stall cycle
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("perf_flush.stall_cnt", PW'(stall_cnt), PW'(4));
    chk("perf_flush.bubble_cnt", PW'(bubble_cnt), PW'(2));
`else
    chk("perf.stall_cnt", PW'(stall_cnt), PW'(0));
    chk("perf.bubble_cnt", PW'(bubble_cnt), PW'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
